fetch_decode: RTL

FETCH_DECODE -- requirements
Module: fetch_decode

---
 rtl/fetch_decode.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_decode.sv
// Instruction fetch and decode front end: PC, data-address and IR registers, memory port muxing
// and field decode. Optional instruction counter enabled by FETCH_DECODE_ICOUNT_EN.
module fetch_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        reset_pc,
  input  logic        load_pc,
  input  logic        addr_sel,
  input  logic        load_ir,
  input  logic        load_addr,
  input  logic [2:0]  mem_cmd,
  input  logic [2:0]  nsel,
  input  logic [15:0] datapath_out,
  input  logic [15:0] read_data,
  output logic [8:0]  mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] write_data,
  output logic [8:0]  pc,
  output logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  reg_num,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic [1:0]  shift,
  output logic [1:0]  alu_op,
`ifdef FETCH_DECODE_ICOUNT_EN
  output logic [15:0] icount,
`endif
  output logic        cmd_err
);

  localparam logic [2:0] CmdNone  = 3'b001;
  localparam logic [2:0] CmdRead  = 3'b010;
  localparam logic [2:0] CmdWrite = 3'b100;

  localparam logic [2:0] SelRn = 3'b001;
  localparam logic [2:0] SelRd = 3'b010;
  localparam logic [2:0] SelRm = 3'b100;

  logic [8:0]  pc_q, pc_d;
  logic [8:0]  addr_q;
  logic [15:0] ir_q;
  logic        err_q;
  logic        cmd_legal;

  always_comb begin
    pc_d = pc_q;
    if (load_pc) begin
      pc_d = reset_pc ? 9'd0 : pc_q + 9'd1;
    end
  end

  always_comb begin
    cmd_legal = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    case (mem_cmd)
      CmdNone:  cmd_legal = 1'b1;
      CmdRead:  begin cmd_legal = 1'b1; mem_rd = 1'b1; end
      CmdWrite: begin cmd_legal = 1'b1; mem_wr = 1'b1; end
      default:  cmd_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= 9'd0;
      addr_q <= 9'd0;
      ir_q   <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (load_addr) addr_q <= datapath_out[8:0];
      // read_data belongs to the address presented before this edge's PC update
      if (load_ir)   ir_q   <= read_data;
      if (!cmd_legal) err_q <= 1'b1;
    end
  end

`ifdef FETCH_DECODE_ICOUNT_EN
  logic [15:0] icount_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      icount_q <= 16'd0;
    end else if (load_ir) begin
      icount_q <= icount_q + 16'd1;
    end
  end

  assign icount = icount_q;
`endif

  assign pc         = pc_q;
  assign ir         = ir_q;
  assign cmd_err    = err_q;
  assign mem_addr   = addr_sel ? pc_q : addr_q;
  assign write_data = datapath_out;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign alu_op = ir_q[12:11];
  assign shift  = ir_q[4:3];
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

  always_comb begin
    case (nsel)
      SelRn:   reg_num = ir_q[10:8];
      SelRd:   reg_num = ir_q[7:5];
      SelRm:   reg_num = ir_q[2:0];
      default: reg_num = 3'b000;
    endcase
  end

endmodule
